// File: rtl/sargantana_icache_pkg.sv
// Shared types and default sizes for the Sargantana instruction-cache fill path.
//   PADDR_W        : physical address width
//   ICACHE_LINE_W  : cache line width in bits
//   ICACHE_BEAT_W  : width of one response beat from the upper level
//   ICACHE_N_BEATS : beats per line
//   ifill_state_t  : fill FSM states
package sargantana_icache_pkg;

    localparam int unsigned PADDR_W        = 40;
    localparam int unsigned ICACHE_LINE_W  = 512;
    localparam int unsigned ICACHE_BEAT_W  = 128;
    localparam int unsigned ICACHE_N_BEATS = ICACHE_LINE_W / ICACHE_BEAT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // waiting for a miss
        REQ   = 2'd1,  // request presented to the upper level, waiting for ready
        RESP  = 2'd2,  // collecting beats into the line register
        DRAIN = 2'd3   // fill was killed; swallow remaining beats silently
    } ifill_state_t;

endpackage

// File: rtl/sargantana_icache_ifill.sv
// Instruction-cache line fill engine.
// Accepts a miss from the icache controller, issues one line-aligned request
// to the upper level, assembles N_BEATS response beats into a full line and
// pulses the line out for one cycle. A kill from the core at any point turns
// the fill into a silent drain of the beats still owed by the upper level.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   ifill_req_valid_i      miss request (only honoured in IDLE)
//   paddr_i                miss physical address
//   kill_i                 flush / kill from the core
//   l2_req_valid_o/_ready_i/_paddr_o   request channel to the upper level
//   l2_resp_valid_i/_data_i            response beats, ascending order
//   ifill_resp_valid_o     data-array write enable (one-cycle pulse)
//   valid_ifill_resp_o     line complete, controller may replay
//   ifill_sent_ack_o       a request is outstanding
//   ifill_line_o           assembled line
//   ifill_paddr_o          line-aligned address of ifill_line_o
module sargantana_icache_ifill #(
    parameter int unsigned PADDR_W = sargantana_icache_pkg::PADDR_W,
    parameter int unsigned LINE_W  = sargantana_icache_pkg::ICACHE_LINE_W,
    parameter int unsigned BEAT_W  = sargantana_icache_pkg::ICACHE_BEAT_W,
    parameter int unsigned N_BEATS = LINE_W / BEAT_W
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               ifill_req_valid_i,
    input  logic [PADDR_W-1:0] paddr_i,
    input  logic               kill_i,
    output logic               l2_req_valid_o,
    input  logic               l2_req_ready_i,
    output logic [PADDR_W-1:0] l2_req_paddr_o,
    input  logic               l2_resp_valid_i,
    input  logic [BEAT_W-1:0]  l2_resp_data_i,
    output logic               ifill_resp_valid_o,
    output logic               valid_ifill_resp_o,
    output logic               ifill_sent_ack_o,
    output logic [LINE_W-1:0]  ifill_line_o,
    output logic [PADDR_W-1:0] ifill_paddr_o
);
    import sargantana_icache_pkg::*;

    // Byte-offset bits inside a line; cleared when the address is latched.
    localparam int unsigned     OFF_W     = $clog2(LINE_W / 8);
    localparam int unsigned     CNT_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

    ifill_state_t        state_q, state_d;
    logic [PADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                killed_q, killed_d;
    logic                pulse_q, pulse_d;
    logic [LINE_W-1:0]   line_q;
    logic                beat_we;
    logic                last_beat;

    // Offset bits never reach the upper level.
    logic unused_paddr_bits;
    assign unused_paddr_bits = ^paddr_i[OFF_W-1:0];

    assign last_beat = l2_resp_valid_i && (cnt_q == LAST_BEAT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        killed_d = killed_q;
        pulse_d  = 1'b0;
        beat_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ifill_req_valid_i && !kill_i) begin
                    addr_d   = {paddr_i[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    cnt_d    = '0;
                    killed_d = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // The request cannot be withdrawn, so a kill here only marks
                // the response for draining once the handshake completes.
                if (l2_req_ready_i) begin
                    state_d = (killed_q || kill_i) ? DRAIN : RESP;
                end else if (kill_i) begin
                    killed_d = 1'b1;
                end
            end
            RESP: begin
                if (l2_resp_valid_i) begin
                    beat_we = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    pulse_d = !kill_i;
                end else if (kill_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (l2_resp_valid_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            killed_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            killed_q <= killed_d;
            pulse_q  <= pulse_d;
        end
    end

    // Beats land in ascending slices of the line; drained beats are dropped
    // so the last good line stays visible.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            line_q <= '0;
        end else if (beat_we) begin
            line_q[cnt_q*BEAT_W +: BEAT_W] <= l2_resp_data_i;
        end
    end

    assign l2_req_valid_o     = (state_q == REQ);
    assign l2_req_paddr_o     = addr_q;
    assign ifill_sent_ack_o   = (state_q != IDLE);
    assign ifill_resp_valid_o = pulse_q;
    assign valid_ifill_resp_o = pulse_q;
    assign ifill_line_o       = line_q;
    assign ifill_paddr_o      = addr_q;

endmodule

// File: tb/tb_sargantana_icache_ifill.sv
// Directed testbench for sargantana_icache_ifill with a transaction-level
// reference model compared against the DUT on every falling clock edge.
module tb_sargantana_icache_ifill;

    localparam int PW = 40;
    localparam int LW = 512;
    localparam int BW = 128;

    logic          clk;
    logic          rstn;
    logic          req_valid;
    logic [PW-1:0] paddr;
    logic          kill;
    logic          l2_req_valid;
    logic          l2_ready;
    logic [PW-1:0] l2_req_paddr;
    logic          l2_resp_valid;
    logic [BW-1:0] l2_data;
    logic          ifill_resp_valid;
    logic          valid_ifill_resp;
    logic          sent_ack;
    logic [LW-1:0] ifill_line;
    logic [PW-1:0] ifill_paddr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sargantana_icache_ifill #(
        .PADDR_W(PW), .LINE_W(LW), .BEAT_W(BW), .N_BEATS(LW / BW)
    ) dut (
        .clk_i              (clk),
        .rstn_i             (rstn),
        .ifill_req_valid_i  (req_valid),
        .paddr_i            (paddr),
        .kill_i             (kill),
        .l2_req_valid_o     (l2_req_valid),
        .l2_req_ready_i     (l2_ready),
        .l2_req_paddr_o     (l2_req_paddr),
        .l2_resp_valid_i    (l2_resp_valid),
        .l2_resp_data_i     (l2_data),
        .ifill_resp_valid_o (ifill_resp_valid),
        .valid_ifill_resp_o (valid_ifill_resp),
        .ifill_sent_ack_o   (sent_ack),
        .ifill_line_o       (ifill_line),
        .ifill_paddr_o      (ifill_paddr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk(input logic [7:0] b);
        return {16{b}};
    endfunction

    // ---------------- reference model (transaction level) ----------------
    // busy: a fill is outstanding; hs: request accepted by the upper level;
    // doom: fill was killed, its remaining beats are discarded.
    logic          m_busy, m_hs, m_doom, m_pulse;
    int            m_cnt;
    logic [PW-1:0] m_addr;
    logic [BW-1:0] m_b [4];

    task automatic model_reset();
        m_busy = 0; m_hs = 0; m_doom = 0; m_pulse = 0; m_cnt = 0; m_addr = '0;
        for (int i = 0; i < 4; i++) m_b[i] = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                model_reset();
            end else begin
                m_pulse = 0;
                if (!m_busy) begin
                    if (req_valid && !kill) begin
                        m_busy = 1; m_hs = 0; m_doom = 0; m_cnt = 0;
                        m_addr = paddr & ~40'h3F;
                    end
                end else if (!m_hs) begin
                    if (kill) m_doom = 1;
                    if (l2_ready) m_hs = 1;
                end else begin
                    if (l2_resp_valid) begin
                        if (!m_doom) m_b[m_cnt] = l2_data;
                        m_cnt++;
                        if (m_cnt == 4) begin
                            m_busy  = 0;
                            m_pulse = !m_doom && !kill;
                        end
                    end
                    if (kill) m_doom = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("l2_req_valid", l2_req_valid, m_busy && !m_hs);
            if (m_busy && !m_hs) chk("l2_req_paddr", l2_req_paddr, m_addr);
            chk("sent_ack", sent_ack, m_busy);
            chk("ifill_resp_valid", ifill_resp_valid, m_pulse);
            chk("valid_ifill_resp", valid_ifill_resp, m_pulse);
            chk("ifill_line", ifill_line, {m_b[3], m_b[2], m_b[1], m_b[0]});
            chk("ifill_paddr", ifill_paddr, m_addr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [PW-1:0] a);
        req_valid = 1; paddr = a;
        step();
        req_valid = 0;
    endtask

    task automatic handshake();
        l2_ready = 1;
        step();
        l2_ready = 0;
    endtask

    task automatic beat(input logic [BW-1:0] d, input logic k);
        l2_resp_valid = 1; l2_data = d; kill = k;
        step();
        l2_resp_valid = 0; kill = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [LW-1:0] line_abcd;
    int            h;
    int            t;

    initial begin
        rstn = 0; req_valid = 0; paddr = '0; kill = 0;
        l2_ready = 0; l2_resp_valid = 0; l2_data = '0;
        step(); step();
        chk("rst_l2_req_valid", l2_req_valid, 0);
        chk("rst_sent_ack", sent_ack, 0);
        chk("rst_line", ifill_line, 0);
        rstn = 1;
        step();

        // Basic fill
        issue(40'h80001234);
        chk("basic_l2_req_valid", l2_req_valid, 1);
        chk("basic_l2_req_paddr", l2_req_paddr, 40'h80001200);
        handshake();
        beat(mk(8'hAA), 0); beat(mk(8'hBB), 0); beat(mk(8'hCC), 0); beat(mk(8'hDD), 0);
        line_abcd = {mk(8'hDD), mk(8'hCC), mk(8'hBB), mk(8'hAA)};
        chk("basic_pulse", ifill_resp_valid, 1);
        chk("basic_valid", valid_ifill_resp, 1);
        chk("basic_line", ifill_line, line_abcd);
        chk("basic_paddr", ifill_paddr, 40'h80001200);
        step();
        chk("basic_pulse_1cyc", ifill_resp_valid, 0);
        chk("basic_line_hold", ifill_line, line_abcd);
        $display("txn basic fill addr=80001234 done");

        // Kill during REQ
        issue(40'h12345678);
        kill = 1; step(); kill = 0;
        step(); step();
        chk("killreq_l2_valid_held", l2_req_valid, 1);
        handshake();
        beat(mk(8'h11), 0); beat(mk(8'h22), 0); beat(mk(8'h33), 0);
        chk("killreq_ack_b2", sent_ack, 1);
        beat(mk(8'h44), 0);
        chk("killreq_ack_fall", sent_ack, 0);
        chk("killreq_no_pulse", ifill_resp_valid, 0);
        chk("killreq_line_kept", ifill_line, line_abcd);
        chk("killreq_paddr", ifill_paddr, 40'h12345640);
        $display("txn kill during REQ addr=12345678 done");

        // Kill on the final beat
        issue(40'h40);
        handshake();
        beat(mk(8'hE0), 0); beat(mk(8'hE1), 0); beat(mk(8'hE2), 0); beat(mk(8'hE3), 1);
        chk("killlast_idle", sent_ack, 0);
        chk("killlast_no_pulse", ifill_resp_valid, 0);
        step();
        chk("killlast_no_pulse2", valid_ifill_resp, 0);
        $display("txn kill on final beat addr=40 done");

        // Gapped beats, with stray response/request traffic that must be ignored
        issue(40'hABCDEF);
        l2_resp_valid = 1; l2_data = mk(8'h99); req_valid = 1; paddr = 40'h5555;
        step();
        l2_resp_valid = 0; req_valid = 0;
        handshake();
        h = cyc;
        for (int i = 0; i < 4; i++) begin
            beat(mk(8'hF0 + 8'(i)), 0);
            if (i < 3) begin
                req_valid = 1; paddr = 40'h7777;
                step();
                req_valid = 0;
            end
        end
        t = 0;
        while (!ifill_resp_valid && t < 10) begin step(); t++; end
        chk("gap_latency", 32'(cyc - h + 1), 8);
        chk("gap_line", ifill_line, {mk(8'hF3), mk(8'hF2), mk(8'hF1), mk(8'hF0)});
        chk("gap_paddr", ifill_paddr, 40'hABCDC0);
        step();
        $display("txn gapped fill addr=ABCDEF done");

        // Reset in the middle of RESP
        issue(40'h1000);
        handshake();
        beat(mk(8'h60), 0); beat(mk(8'h61), 0);
        rstn = 0;
        #1;
        chk("rstmid_l2v", l2_req_valid, 0);
        chk("rstmid_ack", sent_ack, 0);
        chk("rstmid_pulse", ifill_resp_valid, 0);
        chk("rstmid_valid", valid_ifill_resp, 0);
        chk("rstmid_line", ifill_line, 0);
        chk("rstmid_paddr", ifill_paddr, 0);
        chk("rstmid_l2paddr", l2_req_paddr, 0);
        l2_resp_valid = 1; l2_data = mk(8'h62);
        step();
        rstn = 1;
        l2_data = mk(8'h63);
        step();
        l2_resp_valid = 0;
        step();
        chk("rstmid_ignored_ack", sent_ack, 0);
        chk("rstmid_ignored_line", ifill_line, 0);
        issue(40'h20000047);
        handshake();
        beat(mk(8'h70), 0); beat(mk(8'h71), 0); beat(mk(8'h72), 0); beat(mk(8'h73), 0);
        chk("rstmid_new_pulse", ifill_resp_valid, 1);
        chk("rstmid_new_line", ifill_line, {mk(8'h73), mk(8'h72), mk(8'h71), mk(8'h70)});
        chk("rstmid_new_paddr", ifill_paddr, 40'h20000040);
        step();
        $display("txn reset mid-RESP then refill addr=20000047 done");

        // Request coincident with kill
        req_valid = 1; kill = 1; paddr = 40'h3000;
        step();
        req_valid = 0; kill = 0;
        chk("reqkill_l2v", l2_req_valid, 0);
        chk("reqkill_ack", sent_ack, 0);
        step();
        chk("reqkill_l2v2", l2_req_valid, 0);
        $display("txn request with kill addr=3000 done");

        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_ifill.md
SARGANTANA_ICACHE_IFILL -- requirements
Module: sargantana_icache_ifill

Interface
REQ-001 Parameters SHALL be: PADDR_W, default 40, physical address width; LINE_W, default 512, cache line bits; BEAT_W, default 128, response beat bits; N_BEATS = LINE_W/BEAT_W, default 4.
REQ-002 Ports SHALL be, in order:
- clk_i  in  1  clock, all state on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- ifill_req_valid_i  in  1  miss request from the icache controller.
- paddr_i  in  PADDR_W  miss physical address.
- kill_i  in  1  flush or kill from the core.
- l2_req_valid_o  out  1  request to the upper level.
- l2_req_ready_i  in  1  upper level accepts the request.
- l2_req_paddr_o  out  PADDR_W  line-aligned request address.
- l2_resp_valid_i  in  1  response beat valid.
- l2_resp_data_i  in  BEAT_W  response beat data, beats in ascending order.
- ifill_resp_valid_o  out  1  line valid; write enable to the data array.
- valid_ifill_resp_o  out  1  line complete; controller may replay.
- ifill_sent_ack_o  out  1  a request is outstanding.
- ifill_line_o  out  LINE_W  assembled line.
- ifill_paddr_o  out  PADDR_W  line-aligned address of ifill_line_o.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, RESP, DRAIN.
REQ-004 IDLE: when ifill_req_valid_i=1 and kill_i=0, the block SHALL latch paddr_i with the low log2(LINE_W/8) bits cleared, clear the beat counter and the killed flag, and move to REQ. Otherwise it stays in IDLE.
REQ-005 REQ: l2_req_valid_o SHALL be 1 and l2_req_paddr_o SHALL equal the latched address.
- Both SHALL stay stable until l2_req_ready_i=1; a request is never withdrawn.
- On the handshake, the next state SHALL be DRAIN if the killed flag is set or kill_i=1; otherwise RESP.
REQ-006 In REQ, kill_i=1 without a handshake SHALL set the killed flag.
REQ-007 RESP: each cycle with l2_resp_valid_i=1 SHALL write l2_resp_data_i into bits [cnt*BEAT_W +: BEAT_W] of the line register and increment the counter.
REQ-008 RESP, final beat (cnt=N_BEATS-1) with kill_i=0: on the next cycle ifill_resp_valid_o and valid_ifill_resp_o SHALL both pulse high for exactly one cycle, with the full line on ifill_line_o. The FSM returns to IDLE in that same cycle.
REQ-009 RESP, kill_i=1 on any cycle, including the final-beat cycle: no pulse SHALL be generated. The FSM SHALL move to DRAIN, or to IDLE if the final beat was taken that cycle.
REQ-010 DRAIN SHALL consume the remaining beats without producing output, then return to IDLE after the final beat.
REQ-011 ifill_sent_ack_o SHALL be 1 exactly while the state is REQ, RESP or DRAIN.
REQ-012 ifill_req_valid_i outside IDLE SHALL be ignored.
REQ-013 l2_resp_valid_i in IDLE or REQ SHALL be ignored.
REQ-014 Latency: N_BEATS consecutive beats after the handshake SHALL give the pulse exactly one cycle after the last beat. Gaps between beats stretch the latency by one cycle per gap cycle.
REQ-015 ifill_line_o and ifill_paddr_o SHALL hold their values until the next accepted request.

Reset
REQ-016 On rstn_i=0 the block SHALL go to IDLE immediately, regardless of clock.
REQ-017 All outputs, the line register, the address register, the counter and the killed flag SHALL reset to 0.
REQ-018 A reset in the middle of a transaction SHALL abandon it; beats arriving after reset SHALL be ignored.

Structure
REQ-019 ifill_state_t and the default constants (ICACHE_LINE_W, ICACHE_BEAT_W, ICACHE_N_BEATS, PADDR_W) SHALL live in sargantana_icache_pkg.
REQ-020 The block SHALL be a single module with no sub-modules. The beat counter SHALL be log2(N_BEATS) bits wide and wrap to 0 after the final beat.

Verification
REQ-021 Basic fill: paddr_i=0x80001234, ready on the first cycle, beats 0xA..,0xB..,0xC..,0xD.. back-to-back.
- Expect l2_req_paddr_o=0x80001200.
- Expect a one-cycle pulse on both valid outputs, with ifill_line_o = {D,C,B,A}, one cycle after beat D.
REQ-022 Kill during REQ: ready held low 3 cycles, kill_i pulsed on cycle 1.
- l2_req_valid_o stays high until ready.
- All 4 beats are then drained with no pulse.
- ifill_sent_ack_o falls the cycle after beat 3.
REQ-023 Kill on the final beat: kill_i=1 in the same cycle as beat 3.
- No pulse.
- IDLE on the next cycle.
REQ-024 Gapped beats: one idle cycle after each beat.
- Line correct.
- Pulse 8 cycles after the handshake.
REQ-025 Reset mid-RESP: rstn_i low after beat 1.
- All outputs 0.
- Later beats ignored.
- A new request completes correctly.
REQ-026 Request coincident with kill: ifill_req_valid_i=1 and kill_i=1 in IDLE.
- The block stays in IDLE.
- l2_req_valid_o stays 0.
